// File: rtl/bcd_pkg.sv
// Shared constants, FSM state type and digit helpers for the serial packed-BCD adder/subtractor.
package bcd_pkg;

  localparam int BCD_DIGIT_W = 4;
  localparam int BCD_MAX     = 9;
  localparam int BCD_CORR    = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // For an invalid digit (10..15) the 4-bit wrap also yields a value above 9.
  function automatic logic [BCD_DIGIT_W-1:0] nines_comp(input logic [BCD_DIGIT_W-1:0] digit);
    return BCD_DIGIT_W'(BCD_MAX) - digit;
  endfunction

endpackage

// File: rtl/bcd_digit_adder.sv
// One decimal digit of corrected BCD addition: s = (a + b + ci) folded back into 0..9 with carry.
module bcd_digit_adder
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] a,
  input  logic [BCD_DIGIT_W-1:0] b,
  input  logic                   ci,
  output logic [BCD_DIGIT_W-1:0] s,
  output logic                   co,
  output logic                   bad
);

  logic [BCD_DIGIT_W:0]   w_t;
  logic [BCD_DIGIT_W-1:0] w_corr;
  logic                   w_gt;

  assign w_t    = {1'b0, a} + {1'b0, b} + {{BCD_DIGIT_W{1'b0}}, ci};
  assign w_gt   = (w_t > (BCD_DIGIT_W+1)'(BCD_MAX));
  assign w_corr = w_t[BCD_DIGIT_W-1:0] + BCD_DIGIT_W'(BCD_CORR);

  assign s   = w_gt ? w_corr : w_t[BCD_DIGIT_W-1:0];
  assign co  = w_gt;
  assign bad = (a > BCD_DIGIT_W'(BCD_MAX)) | (b > BCD_DIGIT_W'(BCD_MAX));

endmodule

// File: rtl/bcd_serial_addsub.sv
// Digit-serial packed-BCD adder/subtractor: one digit per clock, LS digit first,
// valid/ready on both sides, no overlap between operations.
module bcd_serial_addsub
  import bcd_pkg::*;
#(
  parameter  int NDIGITS = 4,
  localparam int W       = BCD_DIGIT_W * NDIGITS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         err
);

  localparam int CNT_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

  state_t                 r_state;
  state_t                 w_next;
  logic [CNT_W-1:0]       r_cnt;
  logic [W-1:0]           r_a;
  logic [W-1:0]           r_b;
  logic                   r_sub;
  logic                   r_carry;
  logic [W-1:0]           r_sum;
  logic                   r_cout;
  logic                   r_err;

  logic                   w_accept;
  logic                   w_last;
  logic [BCD_DIGIT_W-1:0] w_bd;
  logic [BCD_DIGIT_W-1:0] w_digit;
  logic                   w_co;
  logic                   w_bad;
  logic [W-1:0]           w_sum_shift;

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign err       = r_err;

  assign w_accept = in_valid && (r_state == IDLE);
  assign w_last   = (r_cnt == CNT_W'(NDIGITS - 1));

  assign w_bd = r_sub ? nines_comp(r_b[BCD_DIGIT_W-1:0]) : r_b[BCD_DIGIT_W-1:0];

  bcd_digit_adder u_digit (
    .a   (r_a[BCD_DIGIT_W-1:0]),
    .b   (w_bd),
    .ci  (r_carry),
    .s   (w_digit),
    .co  (w_co),
    .bad (w_bad)
  );

  // New digit enters at the MS end so digit 0 ends up at sum[3:0] after NDIGITS shifts.
  assign w_sum_shift = (r_sum >> BCD_DIGIT_W) | (W'(w_digit) << (W - BCD_DIGIT_W));

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_next = RUN;
      RUN:     if (w_last)   w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_err   <= 1'b0;
    end else if (w_accept) begin
      r_cnt   <= '0;
      r_carry <= sub ? ~cin : cin;
      r_sum   <= '0;
      r_err   <= 1'b0;
    end else if (r_state == RUN) begin
      r_cnt   <= r_cnt + CNT_W'(1);
      r_carry <= w_co;
      r_sum   <= w_sum_shift;
      r_err   <= r_err | w_bad;
      if (w_last) r_cout <= w_co;
    end
  end

  // Operand shift registers carry no reset; they are always loaded on accept.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_a   <= a;
      r_b   <= b;
      r_sub <= sub;
    end else if (r_state == RUN) begin
      r_a <= r_a >> BCD_DIGIT_W;
      r_b <= r_b >> BCD_DIGIT_W;
    end
  end

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Directed bench for bcd_serial_addsub (NDIGITS=4) with a decimal reference model and result scoreboard.
module tb_bcd_serial_addsub;

  localparam int N      = 4;
  localparam int W      = 4 * N;
  localparam int MAXLAT = 64;
  localparam int POW    = 10000;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         err;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         err;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  bcd_serial_addsub #(.NDIGITS(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .err       (err)
  );

  function automatic int bcd2int(input logic [W-1:0] v);
    int r = 0;
    for (int i = N - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int2bcd(input int v);
    logic [W-1:0] r = '0;
    int           x = v;
    for (int i = 0; i < N; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Decimal-value reference for operands made of valid digits only.
  function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                 input logic ms, input logic mc);
    exp_t e;
    int   r;
    if (!ms) begin
      r      = bcd2int(ma) + bcd2int(mb) + int'(mc);
      e.cout = (r >= POW);
      r      = r % POW;
    end else begin
      r      = bcd2int(ma) - bcd2int(mb) - int'(mc);
      e.cout = (r >= 0);
      if (r < 0) r = r + POW;
    end
    e.sum = int2bcd(r);
    e.err = 1'b0;
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic ts, input logic tc);
    a = ta; b = tb; sub = ts; cin = tc; in_valid = 1'b1;
    check("in_ready_idle", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = '1; b = '1; sub = ~ts; cin = ~tc;
  endtask

  task automatic collect(input string tag, input bit release_out);
    int   lat = 0;
    exp_t e;
    while (!out_valid && lat < MAXLAT) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(N));
    check({tag, "_sb_nonempty"}, 32'(sb_q.size() > 0), 32'd1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check({tag, "_sum"}, 32'(sum), 32'(e.sum));
      check({tag, "_cout"}, 32'(cout), 32'(e.cout));
      check({tag, "_err"}, 32'(err), 32'(e.err));
    end
    check({tag, "_busy"}, 32'(in_ready), 32'd0);
    if (release_out) begin
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({tag, "_released"}, {30'd0, out_valid, in_ready}, 32'b01);
    end
  endtask

  task automatic op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                    input logic ts, input logic tc);
    sb_q.push_back(model(ta, tb, ts, tc));
    send(ta, tb, ts, tc);
    collect(tag, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    exp_t         e;
    logic [W-1:0] h_sum;
    logic         h_cout;
    logic         h_err;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; sub = 1'b0; cin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", {14'd0, in_ready, out_valid, sum}, {14'd0, 1'b1, 1'b0, 16'h0000});
    check("rst_cout_err", {30'd0, cout, err}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    op("add_nc",     16'h1234, 16'h5678, 1'b0, 1'b0);
    op("add_chain",  16'h9999, 16'h0001, 1'b0, 1'b0);
    op("add_cin",    16'h0000, 16'h0000, 1'b0, 1'b1);
    op("sub_pos",    16'h5000, 16'h1234, 1'b1, 1'b0);
    op("sub_neg",    16'h1234, 16'h5000, 1'b1, 1'b0);
    op("sub_borrow", 16'h0000, 16'h0000, 1'b1, 1'b1);

    // Digit A (10) produces 10 -> corrected to 0 with carry into the next digit.
    e.sum = 16'h1305; e.cout = 1'b0; e.err = 1'b1;
    sb_q.push_back(e);
    send(16'h12A4, 16'h0001, 1'b0, 1'b0);
    collect("invalid", 1'b1);
    op("after_invalid", 16'h0042, 16'h0058, 1'b0, 1'b0);

    sb_q.push_back(model(16'h0789, 16'h0211, 1'b0, 1'b1));
    send(16'h0789, 16'h0211, 1'b0, 1'b1);
    collect("bp", 1'b0);
    h_sum = sum; h_cout = cout; h_err = err;
    a = 16'h2500; b = 16'h2500; sub = 1'b0; cin = 1'b0; in_valid = 1'b1;
    sb_q.push_back(model(16'h2500, 16'h2500, 1'b0, 1'b0));
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_hold", {12'd0, out_valid, in_ready, cout, err, sum},
                       {12'd0, 1'b1, 1'b0, h_cout, h_err, h_sum});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_idle", {30'd0, out_valid, in_ready}, 32'b01);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_queued_accepted", 32'(in_ready), 32'd0);
    collect("queued", 1'b1);

    send(16'h1111, 16'h2222, 1'b0, 1'b0);
    @(posedge clk); #2;
    check("pre_rst_partial", 32'(sum), 32'h3000);
    rst = 1'b1;
    #1;
    check("midrst_state", {14'd0, in_ready, out_valid, sum}, {14'd0, 1'b1, 1'b0, 16'h0000});
    check("midrst_cout_err", {30'd0, cout, err}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("no_valid_after_rst", {30'd0, out_valid, in_ready}, 32'b01);
    end
    op("post_rst", 16'h0005, 16'h0005, 1'b0, 1'b0);

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
